// File: rtl/moore_ctrl_pkg.sv
// Shared encodings and helpers for the run/pause/step controller around the
// "two consecutive 1s" Moore detector.
package moore_ctrl_pkg;

  typedef enum logic [1:0] {
    DET_A = 2'b00,
    DET_B = 2'b01,
    DET_C = 2'b10
  } det_state_e;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_RUN   = 2'b01,
    CTRL_PAUSE = 2'b10,
    CTRL_DONE  = 2'b11
  } ctrl_state_e;

  // Clock cycles per sample strobe.
  function automatic int calcDiv(input int clkHz, input int tickHz);
    return clkHz / tickHz;
  endfunction

endpackage

// File: rtl/moore_step_controller_if.sv
// Board-side signals of moore_step_controller: command buttons, serial bit w
// and the LED/status outputs.
interface moore_step_controller_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             step;
  logic             w;
  logic             tick;
  logic             z;
  logic [1:0]       tt_ht;
  logic             run;
  logic [CNT_W-1:0] det_count;
  logic             done;

  modport master (
    output start, stop, step, w,
    input  tick, z, tt_ht, run, det_count, done
  );

  modport slave (
    input  start, stop, step, w,
    output tick, z, tt_ht, run, det_count, done
  );
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle sample strobe every DIV enabled clocks;
// i_hold freezes the count, but a wrap in progress always completes.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic Resetn,
  input  logic i_en,
  input  logic i_hold,
  input  logic i_clr,
  output logic o_tick
);
  localparam int PW = $clog2(DIV);

  logic [PW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == PW'(DIV - 1));
  assign o_tick = w_wrap && i_en;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (!i_hold || w_wrap)) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/moore_step_controller.sv
// Run/pause/single-step controller wrapped around the A/B/C "two 1s" Moore
// detector. Define SYNC_W_EN to pass w through a two-flop synchronizer.
module moore_step_controller
  import moore_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int SAMPLES = 16,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    Resetn,
  moore_step_controller_if.slave  bus
);
  localparam int DIV = calcDiv(CLK_HZ, TICK_HZ);
  localparam int SW  = (SAMPLES > 0) ? $clog2(SAMPLES + 1) : 1;

  ctrl_state_e      r_ctrl, w_ctrlNext;
  det_state_e       r_det, w_detNext;
  logic [SW-1:0]    r_sampleCnt;
  logic [CNT_W-1:0] r_detCount;
  logic             r_run;
  logic             r_done;
  logic             w_inRun;
  logic             w_stopped;
  logic             w_startCmd;
  logic             w_stepCmd;
  logic             w_clear;
  logic             w_prescTick;
  logic             w_tick;
  logic             w_lastSample;
  logic             w_wSample;

  assign w_inRun    = (r_ctrl == CTRL_RUN);
  assign w_stopped  = (r_ctrl == CTRL_IDLE) || (r_ctrl == CTRL_PAUSE);
  assign w_startCmd = bus.start && !bus.stop;
  assign w_stepCmd  = bus.step && !bus.start && !bus.stop && w_stopped;
  assign w_clear    = w_startCmd && ((r_ctrl == CTRL_IDLE) || (r_ctrl == CTRL_DONE));
  assign w_tick     = w_prescTick || w_stepCmd;
  assign w_lastSample = (SAMPLES != 0) && (r_sampleCnt >= SW'(SAMPLES - 1));

`ifdef SYNC_W_EN
  logic [1:0] r_wSync;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_wSync <= '0;
    end else begin
      r_wSync <= {r_wSync[0], bus.w};
    end
  end

  assign w_wSample = r_wSync[1];
`else
  assign w_wSample = bus.w;
`endif

  tick_gen #(
    .DIV(DIV)
  ) u_tickGen (
    .clk    (clk),
    .Resetn (Resetn),
    .i_en   (w_inRun),
    .i_hold (bus.stop),
    .i_clr  (w_clear),
    .o_tick (w_prescTick)
  );

  // Reaching the sample limit on a running strobe beats a simultaneous stop.
  always_comb begin
    w_ctrlNext = r_ctrl;
    case (r_ctrl)
      CTRL_IDLE: begin
        if (w_startCmd) w_ctrlNext = CTRL_RUN;
      end
      CTRL_RUN: begin
        if (w_prescTick && w_lastSample) w_ctrlNext = CTRL_DONE;
        else if (bus.stop)               w_ctrlNext = CTRL_PAUSE;
      end
      CTRL_PAUSE, CTRL_DONE: begin
        if (bus.stop)        w_ctrlNext = CTRL_IDLE;
        else if (w_startCmd) w_ctrlNext = CTRL_RUN;
      end
      default: w_ctrlNext = CTRL_IDLE;
    endcase
  end

  always_comb begin
    w_detNext = DET_A;
    case (r_det)
      DET_A:        w_detNext = w_wSample ? DET_B : DET_A;
      DET_B, DET_C: w_detNext = w_wSample ? DET_C : DET_A;
      default:      w_detNext = DET_A;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_ctrl <= CTRL_IDLE;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ctrl <= w_ctrlNext;
      r_run  <= (w_ctrlNext == CTRL_RUN);
      r_done <= (w_ctrlNext == CTRL_DONE);
    end
  end

  // Sample counter saturates at SAMPLES so steps can never push it past DONE.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_det       <= DET_A;
      r_detCount  <= '0;
      r_sampleCnt <= '0;
    end else if (w_clear) begin
      r_det       <= DET_A;
      r_detCount  <= '0;
      r_sampleCnt <= '0;
    end else if (w_tick) begin
      r_det <= w_detNext;
      if ((r_det == DET_B) && (w_detNext == DET_C) && (r_detCount != '1)) begin
        r_detCount <= r_detCount + 1'b1;
      end
      if ((SAMPLES == 0) || (r_sampleCnt != SW'(SAMPLES))) begin
        r_sampleCnt <= r_sampleCnt + 1'b1;
      end
    end
  end

  assign bus.tick      = w_tick;
  assign bus.tt_ht     = r_det;
  assign bus.z         = (r_det == DET_C);
  assign bus.run       = r_run;
  assign bus.done      = r_done;
  assign bus.det_count = r_detCount;
endmodule

// File: tb/tb_moore_step_controller.sv
// Scoreboard bench: dutA runs unlimited samples, dutB stops after 4 samples.
module tb_moore_step_controller;

  logic clk    = 1'b0;
  logic Resetn = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [10:0] qA[$];
  logic [10:0] qB[$];
  logic        sawA = 1'b0;
  logic        sawB = 1'b0;

  localparam logic [5:0] PAT = 6'b110111;

  always #5 clk = ~clk;

  moore_step_controller_if #(.CNT_W(8)) busA ();
  moore_step_controller_if #(.CNT_W(8)) busB ();

  moore_step_controller #(
    .CLK_HZ(8), .TICK_HZ(1), .SAMPLES(0), .CNT_W(8)
  ) dutA (
    .clk    (clk),
    .Resetn (Resetn),
    .bus    (busA)
  );

  moore_step_controller #(
    .CLK_HZ(8), .TICK_HZ(1), .SAMPLES(4), .CNT_W(8)
  ) dutB (
    .clk    (clk),
    .Resetn (Resetn),
    .bus    (busB)
  );

  function automatic logic [10:0] expS(input logic [1:0] tt, input logic [7:0] det);
    return {tt, (tt == 2'b10), det};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample tick before the edge, compare detector state after it.
  always @(posedge clk) begin
    sawA = busA.tick;
    sawB = busB.tick;
  end

  always @(negedge clk) begin
    logic [10:0] act;
    logic [10:0] exp;
    if (sawA) begin
      sawA = 1'b0;
      act = {busA.tt_ht, busA.z, busA.det_count};
      checks++;
      if (qA.size() == 0) begin
        errors++;
        $display("[TB] FAIL sampleA: unexpected tick, got %b", act);
      end else begin
        exp = qA.pop_front();
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL sampleA: got tt/z/det %b expected %b", act, exp);
        end
      end
    end
    if (sawB) begin
      sawB = 1'b0;
      act = {busB.tt_ht, busB.z, busB.det_count};
      checks++;
      if (qB.size() == 0) begin
        errors++;
        $display("[TB] FAIL sampleB: unexpected tick, got %b", act);
      end else begin
        exp = qB.pop_front();
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL sampleB: got tt/z/det %b expected %b", act, exp);
        end
      end
    end
  end

  task automatic applyStimulus(input int sel, input logic iStart, input logic iStop, input logic iStep);
    if (sel == 0) begin
      busA.start = iStart; busA.stop = iStop; busA.step = iStep;
    end else begin
      busB.start = iStart; busB.stop = iStop; busB.step = iStep;
    end
    @(negedge clk);
    busA.start = 1'b0; busA.stop = 1'b0; busA.step = 1'b0;
    busB.start = 1'b0; busB.stop = 1'b0; busB.step = 1'b0;
  endtask

  task automatic waitTick(input int sel, input int expIdx, input bit advance);
    int idx;
    idx = -1;
    for (int i = 0; i <= 40; i++) begin
      if (((sel == 0) ? busA.tick : busB.tick) === 1'b1) begin
        idx = i;
        break;
      end
      @(negedge clk);
    end
    checkOutput(sel == 0 ? "tickDelayA" : "tickDelayB", idx, expIdx);
    if (advance) @(negedge clk);
  endtask

  task automatic countTicks(input int sel, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (((sel == 0) ? busA.tick : busB.tick) === 1'b1) cnt++;
    end
  endtask

  task automatic stepPulse();
    busA.step = 1'b1;
    #1 checkOutput("stepTickHigh", busA.tick, 1);
    @(negedge clk);
    busA.step = 1'b0;
    #1 checkOutput("stepTickLow", busA.tick, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    busA.start = 1'b0; busA.stop = 1'b0; busA.step = 1'b0; busA.w = 1'b0;
    busB.start = 1'b0; busB.stop = 1'b0; busB.step = 1'b0; busB.w = 1'b0;
    #1 Resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetTtA", busA.tt_ht, 0);
    checkOutput("resetZA", busA.z, 0);
    checkOutput("resetRunA", busA.run, 0);
    checkOutput("resetDetA", busA.det_count, 0);
    checkOutput("resetDoneB", busB.done, 0);
    checkOutput("resetTickA", busA.tick, 0);
    Resetn = 1'b1;
    @(negedge clk);

    $display("[TB] run with w pattern 1,1,1,0,1,1");
    busA.w = 1'b1;
    applyStimulus(0, 1, 0, 0);
    checkOutput("runA", busA.run, 1);
    for (int i = 0; i < 6; i++) begin
      busA.w = PAT[i];
      case (i)
        0: qA.push_back(expS(2'b01, 8'd0));
        1: qA.push_back(expS(2'b10, 8'd1));
        2: qA.push_back(expS(2'b10, 8'd1));
        3: qA.push_back(expS(2'b00, 8'd1));
        4: qA.push_back(expS(2'b01, 8'd1));
        default: qA.push_back(expS(2'b10, 8'd2));
      endcase
      waitTick(0, 7, 1);
    end

    $display("[TB] pause at prescaler 3 and resume");
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pauseRunA", busA.run, 0);
    countTicks(0, 20, cnt);
    checkOutput("pauseNoTickA", cnt, 0);
    checkOutput("pauseTtFrozenA", busA.tt_ht, 2'b10);
    applyStimulus(0, 1, 0, 0);
    checkOutput("resumeRunA", busA.run, 1);
    busA.w = 1'b0;
    qA.push_back(expS(2'b00, 8'd2));
    waitTick(0, 4, 1);

    $display("[TB] stop coinciding with tick");
    busA.w = 1'b1;
    qA.push_back(expS(2'b01, 8'd2));
    waitTick(0, 7, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("stopTickRunA", busA.run, 0);
    checkOutput("stopTickDoneA", busA.done, 0);
    applyStimulus(0, 0, 1, 0);

    $display("[TB] single steps in IDLE");
    qA.push_back(expS(2'b10, 8'd3));
    stepPulse();
    qA.push_back(expS(2'b10, 8'd3));
    stepPulse();
    checkOutput("stepRunA", busA.run, 0);

    $display("[TB] restart then async reset mid-run");
    applyStimulus(0, 1, 0, 0);
    checkOutput("restartTtA", busA.tt_ht, 0);
    checkOutput("restartDetA", busA.det_count, 0);
    qA.push_back(expS(2'b01, 8'd0));
    waitTick(0, 7, 1);
    qA.push_back(expS(2'b10, 8'd1));
    waitTick(0, 7, 1);
    repeat (2) @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("midResetTtA", busA.tt_ht, 0);
    checkOutput("midResetZA", busA.z, 0);
    checkOutput("midResetRunA", busA.run, 0);
    checkOutput("midResetDetA", busA.det_count, 0);
    checkOutput("midResetTickA", busA.tick, 0);
    @(negedge clk);
    Resetn = 1'b1;
    @(negedge clk);

    $display("[TB] SAMPLES=4 run to DONE");
    busB.w = 1'b1;
    applyStimulus(1, 1, 0, 0);
    qB.push_back(expS(2'b01, 8'd0));
    waitTick(1, 7, 1);
    qB.push_back(expS(2'b10, 8'd1));
    waitTick(1, 7, 1);
    qB.push_back(expS(2'b10, 8'd1));
    waitTick(1, 7, 1);
    qB.push_back(expS(2'b10, 8'd1));
    waitTick(1, 7, 1);
    checkOutput("doneB", busB.done, 1);
    checkOutput("doneRunB", busB.run, 0);
    countTicks(1, 20, cnt);
    checkOutput("doneNoTickB", cnt, 0);
    checkOutput("doneTtHeldB", busB.tt_ht, 2'b10);
    checkOutput("doneDetHeldB", busB.det_count, 1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("restartDoneB", busB.done, 0);
    checkOutput("restartRunB", busB.run, 1);
    checkOutput("restartDetB", busB.det_count, 0);
    checkOutput("restartTtB", busB.tt_ht, 0);
    qB.push_back(expS(2'b01, 8'd0));
    waitTick(1, 7, 1);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    repeat (2) @(negedge clk);

    checkOutput("queueEmptyA", qA.size(), 0);
    checkOutput("queueEmptyB", qB.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_step_controller.md
Name: moore_step_controller

Overview:
Run/pause/single-step controller for the "two consecutive 1s" Moore detector (states A/B/C, z=1 in C).
- Replaces the derived 1 Hz clock with a clock-enable strobe generated from clk, so the whole block runs in one clock domain.
- Sequences sampling of w, counts detections and stops after a programmed number of samples.
- Sits between board inputs (buttons, switch w) and the LED outputs z, tt_ht and done.

Parameters:
CLK_HZ, 50_000_000, input clock frequency
TICK_HZ, 1, sample strobe rate; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2
SAMPLES, 16, samples per run; 0 = unlimited
CNT_W, 8, width of det_count

Ports:
clk  input  1  system clock
Resetn  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin or resume run
stop  input  1  one-cycle pulse: pause or abort
step  input  1  one-cycle pulse: take one sample while not running
w  input  1  serial data bit
tick  output  1  high during the cycle whose closing edge samples w
z  output  1  Moore output, 1 when tt_ht == C
tt_ht  output  2  detector state: A=00, B=01, C=10
run  output  1  controller in RUN
det_count  output  CNT_W  number of B->C transitions, saturating
done  output  1  level, SAMPLES samples completed

Behaviour:
- Reset (async, Resetn low): ctrl=IDLE, tt_ht=A, z=0, tick=0, run=0, done=0, det_count=0, prescaler=0, sample counter=0.
- Controller states: IDLE, RUN, PAUSE, DONE. Command priority: stop > start > step.
- IDLE:
  - start -> RUN; same edge clears prescaler, sample counter, det_count; tt_ht <= A.
  - step -> one sample (tick=1 this cycle); stays IDLE.
- RUN:
  - Prescaler increments every clk.
  - tick = (prescaler == DIV-1) && RUN, combinational. Prescaler wraps to 0 on that edge.
  - stop -> PAUSE; prescaler holds its value. If tick is also high that cycle, the sample is still taken.
  - start and step are ignored.
- PAUSE:
  - start -> RUN, resuming prescaler from its held value.
  - step -> one sample.
  - stop -> IDLE; tt_ht and counters retained.
- Sample edge (tick=1): detector next state from w.
  - A: w ? B : A
  - B: w ? C : A
  - C: w ? C : A
  - Illegal encoding 11 -> A.
- det_count increments on a sample edge where B->C, saturating at all-ones.
- Sample counter:
  - Increments on every sample, including steps.
  - When SAMPLES != 0 and the counter reaches SAMPLES on a RUN sample edge: ctrl -> DONE, done=1. This takes precedence over a simultaneous stop.
  - Steps in IDLE/PAUSE never enter DONE; the counter saturates at SAMPLES.
- DONE: tt_ht, det_count and z held. start -> RUN (cleared as from IDLE); stop -> IDLE with done=0.
- run = (ctrl == RUN), registered. z = (tt_ht == C), Moore, no dependence on w.
- Latency: w sampled on the tick edge; tt_ht/z valid the next cycle.
- Mid-operation Resetn: immediate return to reset values regardless of state.

Optional Feature:
SYNC_W_EN
- Defined: w passes through a two-flop synchronizer before the detector. The sampled value is w from 2 clk earlier.
- Undefined: w is used directly at the sample edge. Use only with already-synchronous w.

Decomposition:
- Package moore_ctrl_pkg:
  - detector state encodings A/B/C (2-bit)
  - controller state encodings IDLE/RUN/PAUSE/DONE (2-bit)
  - DIV computation function
- One sub-module, tick_gen: prescaler with en (hold), clr, and tick output.
- Detector FSM and controller stay in the top.

Test Plan:
1. CLK_HZ=8, TICK_HZ=1 (DIV=8), SAMPLES=0; reset, start, w=1 -> tick every 8 clk; tt_ht 00->01->10; z=1 after second tick; det_count=1.
2. w pattern 1,1,1,0,1,1 on successive ticks -> tt_ht B,C,C,A,B,C; det_count=2; z high exactly in the C cycles.
3. Stop at prescaler=3 in RUN, wait 20 clk, start -> run=0 and tt_ht frozen during pause; next tick arrives 4 clk after resume.
4. SAMPLES=4, w=1 -> done=1 after 4th tick; run=0; further ticks absent; start restarts with det_count=0.
5. In IDLE, pulse step with w=1 twice -> tick=1 for one clk each; tt_ht=C; run stays 0.
6. Resetn low mid-run with tt_ht=C -> all outputs reset asynchronously. Also: stop coinciding with tick -> sample taken, then PAUSE.
